stream_rr_arbiter: RTL

Round-robin N-to-1 valid/ready stream arbiter with handshake lock-in. It sits directly upstream of a spill register in the AXI channel muxing path: it selects one requesting input per cycle and presents its payload and index on a single output stream. The downstream spill register cuts the combinational valid/ready paths this block leaves open.

---
 rtl/stream_rr_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/stream_rr_arbiter.sv
// Round-robin N-to-1 valid/ready stream arbiter, zero-latency, feeding a spill register.
// Define STREAM_RR_ARBITER_LOCK_EN to hold a stalled grant until its handshake.
module stream_rr_arbiter #(
    parameter int NumInp    = 4,
    parameter int DataWidth = 32,
    localparam int IdxWidth = (NumInp > 1) ? $clog2(NumInp) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NumInp-1:0]             inp_valid_i,
    output logic [NumInp-1:0]             inp_ready_o,
    input  logic [NumInp*DataWidth-1:0]   inp_data_i,
    output logic                          oup_valid_o,
    input  logic                          oup_ready_i,
    output logic [DataWidth-1:0]          oup_data_o,
    output logic [IdxWidth-1:0]           oup_idx_o
);

    logic [IdxWidth-1:0] rr_q, rr_d;
    logic [IdxWidth-1:0] scan_idx;
    logic [IdxWidth-1:0] winner;
    logic                any_valid;

    // Scan from the far end of the priority order back toward rr_q so the
    // last hit is the first requester at or after the pointer.
    always_comb begin
        logic [IdxWidth:0] pos;
        pos      = '0;
        scan_idx = rr_q;
        for (int i = NumInp - 1; i >= 0; i--) begin
            pos = {1'b0, rr_q} + (IdxWidth + 1)'(i);
            if (pos >= (IdxWidth + 1)'(NumInp)) begin
                pos = pos - (IdxWidth + 1)'(NumInp);
            end
            if (inp_valid_i[pos[IdxWidth-1:0]]) begin
                scan_idx = pos[IdxWidth-1:0];
            end
        end
    end

    assign any_valid = |inp_valid_i;

`ifdef STREAM_RR_ARBITER_LOCK_EN
    logic                lock_q, lock_d;
    logic [IdxWidth-1:0] lock_idx_q, lock_idx_d;

    always_comb begin
        winner      = scan_idx;
        oup_valid_o = any_valid;
        if (lock_q) begin
            winner      = lock_idx_q;
            oup_valid_o = inp_valid_i[lock_idx_q];
        end
    end
`else
    always_comb begin
        winner      = scan_idx;
        oup_valid_o = any_valid;
    end
`endif

    always_comb begin
        oup_data_o  = '0;
        inp_ready_o = '0;
        for (int k = 0; k < NumInp; k++) begin
            if (IdxWidth'(k) == winner) begin
                oup_data_o     = inp_data_i[k*DataWidth +: DataWidth];
                inp_ready_o[k] = oup_valid_o && oup_ready_i;
            end
        end
    end

    assign oup_idx_o = winner;

    always_comb begin
        rr_d = rr_q;
        if (oup_valid_o && oup_ready_i) begin
            rr_d = (winner == IdxWidth'(NumInp - 1)) ? '0 : winner + 1'b1;
        end
    end

`ifdef STREAM_RR_ARBITER_LOCK_EN
    always_comb begin
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (oup_valid_o && oup_ready_i) begin
            lock_d = 1'b0;
        end else if (oup_valid_o) begin
            lock_d     = 1'b1;
            lock_idx_d = winner;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            rr_q       <= rr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end
`else
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

endmodule
